// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encodings, directions, lamp levels and second-to-cycle helper
package traffic_pkg;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_RED_TO_EW = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_RED_TO_NS = 3'd5,
    S_EMERG     = 3'd6
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  localparam logic LAMP_ON  = 1'b1;
  localparam logic LAMP_OFF = 1'b0;

  // 32-bit product of seconds and clock rate; a zero-length phase would never
  // assert done, so it is stretched to a single cycle.
  function automatic logic [31:0] sec_to_cycles(input logic [31:0] sec, input logic [31:0] freq);
    logic [31:0] cycles;
    cycles = sec * freq;
    return (cycles == 32'd0) ? 32'd1 : cycles;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase cycle counter with clear, done compare and saturate mode
module phase_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        saturate,
  input  logic [31:0] duration,
  output logic [31:0] count,
  output logic        done
);

  // count cycles in the current phase; restart on clear, pin at all-ones when saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (clear) begin
      count <= 32'd0;
    end else if (saturate && (count == 32'hFFFF_FFFF)) begin
      count <= count;
    end else begin
      count <= count + 32'd1;
    end
  end

  assign done = (count == (duration - 32'd1));

endmodule

// File: rtl/intersection_phase_controller.sv
// rtl/intersection_phase_controller.sv - four-way intersection vehicle phase FSM with emergency all-red hold
module intersection_phase_controller #(
  parameter int unsigned CLK_FREQ          = 50_000_000,
  parameter int unsigned YELLOW_SEC        = 3,
  parameter int unsigned ALL_RED_SEC       = 2,
  parameter int unsigned DEFAULT_GREEN_SEC = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cfg_ns_green_sec,
  input  logic [7:0]  cfg_ew_green_sec,
  input  logic        emerg_req,
  output logic        NS_GREEN,
  output logic        NS_YELLOW,
  output logic        NS_RED,
  output logic        EW_GREEN,
  output logic        EW_YELLOW,
  output logic        EW_RED,
  output logic [31:0] ns_green_delay,
  output logic [31:0] ew_green_delay,
  output logic [2:0]  phase_state,
  output logic [31:0] phase_counter,
  output logic        emerg_active
);
  import traffic_pkg::*;

  localparam logic [31:0] YEL_CYC       = sec_to_cycles(32'(YELLOW_SEC), 32'(CLK_FREQ));
  localparam logic [31:0] AR_CYC        = sec_to_cycles(32'(ALL_RED_SEC), 32'(CLK_FREQ));
  localparam logic [31:0] DEF_GREEN_CYC = sec_to_cycles(32'(DEFAULT_GREEN_SEC), 32'(CLK_FREQ));

  phase_e      state, next_state;
  dir_e        last_dir;
  logic [31:0] duration;
  logic [31:0] ns_green_new, ew_green_new;
  logic        done;
  logic        ns_entry, ew_entry;
  logic        ns_g_n, ns_y_n, ns_r_n, ew_g_n, ew_y_n, ew_r_n;

  assign ns_green_new = sec_to_cycles((cfg_ns_green_sec == 8'd0) ? 32'(DEFAULT_GREEN_SEC)
                                      : {24'd0, cfg_ns_green_sec}, 32'(CLK_FREQ));
  assign ew_green_new = sec_to_cycles((cfg_ew_green_sec == 8'd0) ? 32'(DEFAULT_GREEN_SEC)
                                      : {24'd0, cfg_ew_green_sec}, 32'(CLK_FREQ));

  assign ns_entry = (next_state == S_NS_GREEN) && (state != S_NS_GREEN);
  assign ew_entry = (next_state == S_EW_GREEN) && (state != S_EW_GREEN);

  // greens run off the value latched at entry so mid-phase config edits wait for the next green
  always_comb begin
    duration = AR_CYC;
    case (state)
      S_NS_GREEN:               duration = ns_green_delay;
      S_EW_GREEN:               duration = ew_green_delay;
      S_NS_YELLOW, S_EW_YELLOW: duration = YEL_CYC;
      default:                  duration = AR_CYC;
    endcase
  end

  phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (next_state != state),
    .saturate (state == S_EMERG),
    .duration (duration),
    .count    (phase_counter),
    .done     (done)
  );

  // next phase and the lamp pattern that goes with it
  always_comb begin
    next_state = state;
    ns_g_n = LAMP_OFF;
    ns_y_n = LAMP_OFF;
    ns_r_n = LAMP_ON;
    ew_g_n = LAMP_OFF;
    ew_y_n = LAMP_OFF;
    ew_r_n = LAMP_ON;
    case (state)
      S_NS_GREEN:  if (emerg_req || done) next_state = S_NS_YELLOW;
      S_NS_YELLOW: if (done) next_state = emerg_req ? S_EMERG : S_RED_TO_EW;
      S_RED_TO_EW: if (done) next_state = emerg_req ? S_EMERG : S_EW_GREEN;
      S_EW_GREEN:  if (emerg_req || done) next_state = S_EW_YELLOW;
      S_EW_YELLOW: if (done) next_state = emerg_req ? S_EMERG : S_RED_TO_NS;
      S_RED_TO_NS: if (done) next_state = emerg_req ? S_EMERG : S_NS_GREEN;
      S_EMERG:     if (!emerg_req) next_state = (last_dir == DIR_NS) ? S_RED_TO_EW : S_RED_TO_NS;
      default:     next_state = S_RED_TO_NS;
    endcase
    case (next_state)
      S_NS_GREEN:  begin ns_g_n = LAMP_ON; ns_r_n = LAMP_OFF; end
      S_NS_YELLOW: begin ns_y_n = LAMP_ON; ns_r_n = LAMP_OFF; end
      S_EW_GREEN:  begin ew_g_n = LAMP_ON; ew_r_n = LAMP_OFF; end
      S_EW_YELLOW: begin ew_y_n = LAMP_ON; ew_r_n = LAMP_OFF; end
      default:     ;
    endcase
  end

  // phase register with lamps decoded from the incoming phase so they change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RED_TO_NS;
      NS_GREEN     <= LAMP_OFF;
      NS_YELLOW    <= LAMP_OFF;
      NS_RED       <= LAMP_ON;
      EW_GREEN     <= LAMP_OFF;
      EW_YELLOW    <= LAMP_OFF;
      EW_RED       <= LAMP_ON;
      emerg_active <= 1'b0;
    end else begin
      state        <= next_state;
      NS_GREEN     <= ns_g_n;
      NS_YELLOW    <= ns_y_n;
      NS_RED       <= ns_r_n;
      EW_GREEN     <= ew_g_n;
      EW_YELLOW    <= ew_y_n;
      EW_RED       <= ew_r_n;
      emerg_active <= (next_state == S_EMERG);
    end
  end

  // green lengths and last served direction captured on green entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_green_delay <= DEF_GREEN_CYC;
      ew_green_delay <= DEF_GREEN_CYC;
      last_dir       <= DIR_EW;
    end else if (ns_entry) begin
      ns_green_delay <= ns_green_new;
      last_dir       <= DIR_NS;
    end else if (ew_entry) begin
      ew_green_delay <= ew_green_new;
      last_dir       <= DIR_EW;
    end
  end

  assign phase_state = state;

endmodule

// File: tb/tb_intersection_phase_controller.sv
// tb/tb_intersection_phase_controller.sv - scoreboard bench with phase-level reference model
module tb_intersection_phase_controller;

  localparam int F   = 10;
  localparam int YEL = 10;
  localparam int AR  = 10;
  localparam int DEF = 4;

  logic        clk, rst_n, emerg_req;
  logic [7:0]  cfg_ns_green_sec, cfg_ew_green_sec;
  logic        NS_GREEN, NS_YELLOW, NS_RED, EW_GREEN, EW_YELLOW, EW_RED;
  logic [31:0] ns_green_delay, ew_green_delay, phase_counter;
  logic [2:0]  phase_state;
  logic        emerg_active;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int st;
    int cyc;
    int nsd;
    int ewd;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int cyc = 0;
  int m_st = 5;
  int m_left = AR;
  int m_nsd = DEF * F;
  int m_ewd = DEF * F;
  bit m_last_ns = 1'b0;
  int nxt;
  int next_of[6] = '{1, 2, 3, 4, 5, 0};

  int prev_state = 5;
  int cur_exp = 5;
  int last_entry = 0;

  intersection_phase_controller #(
    .CLK_FREQ(F), .YELLOW_SEC(1), .ALL_RED_SEC(1), .DEFAULT_GREEN_SEC(DEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_ns_green_sec(cfg_ns_green_sec), .cfg_ew_green_sec(cfg_ew_green_sec),
    .emerg_req(emerg_req),
    .NS_GREEN(NS_GREEN), .NS_YELLOW(NS_YELLOW), .NS_RED(NS_RED),
    .EW_GREEN(EW_GREEN), .EW_YELLOW(EW_YELLOW), .EW_RED(EW_RED),
    .ns_green_delay(ns_green_delay), .ew_green_delay(ew_green_delay),
    .phase_state(phase_state), .phase_counter(phase_counter),
    .emerg_active(emerg_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int green_cycles(input logic [7:0] s);
    return ((s == 8'd0) ? DEF : int'(s)) * F;
  endfunction

  // lamp triple {green, yellow, red} seen by each approach in a given phase
  function automatic logic [31:0] lamps_ns(input int st);
    return (st == 0) ? 32'd4 : (st == 1) ? 32'd2 : 32'd1;
  endfunction
  function automatic logic [31:0] lamps_ew(input int st);
    return (st == 3) ? 32'd4 : (st == 4) ? 32'd2 : 32'd1;
  endfunction

  task automatic enter(input int s);
    m_st = s;
    case (s)
      0: begin m_nsd = green_cycles(cfg_ns_green_sec); m_left = m_nsd; m_last_ns = 1'b1; end
      3: begin m_ewd = green_cycles(cfg_ew_green_sec); m_left = m_ewd; m_last_ns = 1'b0; end
      1, 4: m_left = YEL;
      default: m_left = AR;
    endcase
    sb.push_back('{s, cyc, m_nsd, m_ewd});
  endtask

  // reference model: each phase is a countdown of remaining cycles
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_st = 5; m_left = AR; m_nsd = DEF * F; m_ewd = DEF * F;
      m_last_ns = 1'b0; cyc = 0; sb.delete();
    end else begin
      cyc++;
      nxt = -1;
      case (m_st)
        0, 3: begin
          if (emerg_req) nxt = m_st + 1;
          else begin
            m_left--;
            if (m_left == 0) nxt = m_st + 1;
          end
        end
        6: if (!emerg_req) nxt = m_last_ns ? 2 : 5;
        default: begin
          m_left--;
          if (m_left == 0) nxt = emerg_req ? 6 : next_of[m_st];
        end
      endcase
      if (nxt >= 0) enter(nxt);
    end
  end

  // monitor: pop on every DUT phase change, check lamps/counter/safety every cycle
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_state = 5; cur_exp = 5; last_entry = 0;
    end else begin
      if (int'(phase_state) != prev_state) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL transition at cycle %0d: got state %0d, expected no change from %0d",
                   cyc, phase_state, prev_state);
        end else begin
          e = sb.pop_front();
          chk("phase_state", 32'(phase_state), e.st);
          chk("entry_cycle", cyc, e.cyc);
          chk("ns_green_delay", ns_green_delay, e.nsd);
          chk("ew_green_delay", ew_green_delay, e.ewd);
          cur_exp = e.st; last_entry = e.cyc;
        end
        prev_state = int'(phase_state);
      end
      chk("ns_lamps", 32'({NS_GREEN, NS_YELLOW, NS_RED}), lamps_ns(cur_exp));
      chk("ew_lamps", 32'({EW_GREEN, EW_YELLOW, EW_RED}), lamps_ew(cur_exp));
      chk("emerg_active", 32'(emerg_active), 32'(cur_exp == 6));
      chk("phase_counter", phase_counter, cyc - last_entry);
      chk("safety", 32'((NS_GREEN | NS_YELLOW) & (EW_GREEN | EW_YELLOW)), 32'd0);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while ((int'(phase_state) != s) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (int'(phase_state) != s) begin
      checks++; errors++;
      $display("FAIL wait_state: got state %0d, expected %0d within %0d cycles", phase_state, s, budget);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(phase_state), 32'd5);
    chk({tag, "_counter"}, phase_counter, 32'd0);
    chk({tag, "_ns_lamps"}, 32'({NS_GREEN, NS_YELLOW, NS_RED}), 32'd1);
    chk({tag, "_ew_lamps"}, 32'({EW_GREEN, EW_YELLOW, EW_RED}), 32'd1);
    chk({tag, "_ns_delay"}, ns_green_delay, DEF * F);
    chk({tag, "_ew_delay"}, ew_green_delay, DEF * F);
    chk({tag, "_emerg"}, 32'(emerg_active), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; emerg_req = 1'b0;
    cfg_ns_green_sec = 8'd3; cfg_ew_green_sec = 8'd2;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    run(200);

    wait_state(3, 200);
    run(5);
    cfg_ew_green_sec = 8'd5;
    cfg_ns_green_sec = 8'd0;
    run(250);

    wait_state(0, 300);
    n = 0;
    while ((phase_counter != 32'd5) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk("emerg_start_counter", phase_counter, 32'd5);
    emerg_req = 1'b1;
    run(40);
    emerg_req = 1'b0;
    run(120);

    for (int i = 0; i < 25; i++) begin
      cfg_ns_green_sec = 8'($urandom_range(0, 6));
      cfg_ew_green_sec = 8'($urandom_range(0, 6));
      run($urandom_range(1, 60));
      emerg_req = ($urandom_range(0, 3) == 0);
    end
    emerg_req = 1'b0;
    run(100);

    wait_state(2, 300);
    wait_state(1, 300);
    run($urandom_range(1, 8));
    #1 rst_n = 1'b0;
    #1 chk_reset("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(120);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
